ifetch: RTL and testbench
=========================

IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameter DWIDTH, default 16: instruction width in bits.
REQ-002 Parameter AWIDTH, default 8: instruction address width in bits.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 run  input  1  fetch enable; 0 means no new memory requests are issued.
REQ-006 jmp_en  input  1  redirect strobe, one cycle.
REQ-007 jmp_addr  input  AWIDTH  redirect target address.
REQ-008 mem_req  output  1  memory read request, one-cycle pulse.
REQ-009 mem_addr  output  AWIDTH  read address; valid while mem_req=1.
REQ-010 mem_rvalid  input  1  read-data valid; exactly one per request, latency >=1 cycle.
REQ-011 mem_rdata  input  DWIDTH  read data; valid while mem_rvalid=1.
REQ-012 ins  output  DWIDTH  instruction word at the buffer head; drives the instruction register's data input.
REQ-013 ins_valid  output  1  buffer non-empty; drives the instruction register's load enable.
REQ-014 ins_ready  input  1  consumer accepts ins this cycle.
REQ-015 pc  output  AWIDTH  address of the next request to issue.

Function
REQ-016 FSM states: IDLE, REQ, WAIT.
REQ-017 IDLE->REQ when run=1, jmp_en=0, and the buffer has a free slot that no in-flight request has reserved; otherwise the FSM stays in IDLE.
REQ-018 REQ: mem_req=1 and mem_addr=pc for exactly one cycle, then WAIT; mem_req=0 in all other states.
REQ-019 At most one request is outstanding.
REQ-020 WAIT: on mem_rvalid=1, push mem_rdata into the buffer, set pc <= pc+1, and go to IDLE.
REQ-021 pc increments modulo 2^AWIDTH; 2^AWIDTH-1 wraps to 0.
REQ-022 Buffer is a FIFO; ins = head entry, ins_valid = (count!=0).
REQ-023 Pop occurs when ins_valid && ins_ready.
REQ-024 Push and pop in the same cycle leave the count unchanged; this is legal when the buffer is full.
REQ-025 When the buffer is empty, ins holds its last value (0 after reset).
REQ-026 jmp_en=1: pc <= jmp_addr, the buffer is flushed (count=0, ins_valid=0 next cycle), and any same-cycle pop is void.
REQ-027 jmp_en=1 in REQ or WAIT sets a drop flag; the next mem_rvalid is discarded, pc is not incremented, and the flag clears.
REQ-028 jmp_en=1 in the same cycle as mem_rvalid discards that data; pc = jmp_addr.
REQ-029 With a flushed request in flight, the FSM waits for its mem_rvalid before issuing a new request.
REQ-030 Redirect-to-first-request latency: from IDLE, jmp_en in cycle N gives mem_req=1 with mem_addr=jmp_addr in cycle N+2 when run=1.
REQ-031 run=0 in WAIT does not cancel the in-flight request; its data is buffered normally.

Reset
REQ-032 rst=1 forces: state=IDLE, pc=0, mem_req=0, count=0, ins_valid=0, ins=0, drop flag=0.
REQ-033 rst has priority over all other inputs.
REQ-034 A response arriving after reset for a request issued before reset is ignored: the drop flag is set while in WAIT at reset, and the response is awaited.

Configuration
REQ-035 Macro IFETCH_PREFETCH_EN defined: buffer depth 2, so a second fetch may issue while the head waits for ins_ready.
REQ-036 IFETCH_PREFETCH_EN undefined: buffer depth 1; a new request issues only when the buffer is empty or is popped in the same cycle as the IDLE decision.
REQ-037 Interface and all other behaviour are identical in both builds.

Verification
REQ-038 Reset, run=1, ins_ready=1, memory latency 1, mem[k]=k+0x100 -> mem_addr 0,1,2... and ins 0x100,0x101,0x102 in order; one word every 3 cycles.
REQ-039 Set pc=0xFF via jmp, then run -> mem_addr 0xFF, then 0x00.
REQ-040 ins_ready=0, run=1 -> with the macro, exactly 2 requests then mem_req stays 0; without it, exactly 1; ins_valid=1 held, ins unchanged.
REQ-041 jmp_en, jmp_addr=0x40, during WAIT with latency 3 -> stale data not delivered; the next mem_req has addr 0x40 after the stale mem_rvalid; first ins = mem[0x40].
REQ-042 jmp_en with buffer full and ins_ready=1 in the same cycle -> no pop counted, ins_valid=0 next cycle, pc=jmp_addr.
REQ-043 rst pulsed while in WAIT -> all outputs at reset values next cycle; the late mem_rvalid does not raise ins_valid.

Source files
------------

// File: rtl/ifetch.sv
// Instruction fetch unit: issues single-outstanding memory reads, buffers the
// returned words in a small FIFO and handles redirects (jmp) by flushing the
// buffer and discarding the response of any request already in flight.
// Build option: define IFETCH_PREFETCH_EN for a 2-entry buffer (prefetch one
// word ahead of the consumer); otherwise the buffer holds a single word.
module ifetch #(
   parameter int unsigned DWIDTH = 16,
   parameter int unsigned AWIDTH = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   input  logic              jmp_en,
   input  logic [AWIDTH-1:0] jmp_addr,
   output logic              mem_req,
   output logic [AWIDTH-1:0] mem_addr,
   input  logic              mem_rvalid,
   input  logic [DWIDTH-1:0] mem_rdata,
   output logic [DWIDTH-1:0] ins,
   output logic              ins_valid,
   input  logic              ins_ready,
   output logic [AWIDTH-1:0] pc
);

`ifdef IFETCH_PREFETCH_EN
   localparam int unsigned DEPTH = 2;
`else
   localparam int unsigned DEPTH = 1;
`endif
   localparam int unsigned CW = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   state_t                        state_q, state_d;
   logic [AWIDTH-1:0]             pc_q, pc_d;
   logic                          drop_q, drop_d;
   logic [CW-1:0]                 count_q, count_d;
   logic [DEPTH-1:0][DWIDTH-1:0]  fifo_q, fifo_d;
   logic                          mem_req_q, mem_req_d;
   logic                          ins_valid_q, ins_valid_d;

   logic          pop;
   logic          push;
   logic          free;
   logic          keep_wait;
   logic [CW-1:0] cnt_pop;

   // Next-state, pc, drop flag and buffer update
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      drop_d    = drop_q;
      fifo_d    = fifo_q;
      push      = 1'b0;
      pop       = ins_valid_q && ins_ready && !jmp_en;
      free      = (count_q < CW'(DEPTH)) || pop;
      cnt_pop   = count_q - CW'(pop);
      // A request issued before reset must still be waited for, so its late
      // response cannot be mistaken for a fresh one.
      keep_wait = (state_q == S_REQ) || ((state_q == S_WAIT) && !mem_rvalid);

      case (state_q)
         S_IDLE: begin
            if (run && !jmp_en && free) state_d = S_REQ;
         end
         S_REQ: begin
            state_d = S_WAIT;
            if (jmp_en) drop_d = 1'b1;
         end
         S_WAIT: begin
            if (mem_rvalid) begin
               state_d = S_IDLE;
               drop_d  = 1'b0;
               if (!drop_q && !jmp_en) begin
                  push = 1'b1;
                  pc_d = pc_q + AWIDTH'(1);
               end
            end else if (jmp_en) begin
               drop_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (jmp_en) pc_d = jmp_addr;

      // Shift on pop only when a younger entry exists; a lone head is kept
      // so ins holds its last value once the buffer drains.
      for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
         if (pop && (count_q > CW'(1))) fifo_d[i] = fifo_q[i+1];
      end
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (push && (cnt_pop == CW'(i))) fifo_d[i] = mem_rdata;
      end

      count_d     = jmp_en ? '0 : (cnt_pop + CW'(push));
      mem_req_d   = (state_d == S_REQ);
      ins_valid_d = (count_d != '0);
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= keep_wait ? S_WAIT : S_IDLE;
         drop_q      <= keep_wait;
         pc_q        <= '0;
         count_q     <= '0;
         fifo_q      <= '0;
         mem_req_q   <= 1'b0;
         ins_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         drop_q      <= drop_d;
         pc_q        <= pc_d;
         count_q     <= count_d;
         fifo_q      <= fifo_d;
         mem_req_q   <= mem_req_d;
         ins_valid_q <= ins_valid_d;
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_addr  = pc_q;
   assign pc        = pc_q;
   assign ins       = fifo_q[0];
   assign ins_valid = ins_valid_q;

endmodule

// File: tb/tb_ifetch.sv
// Directed testbench for ifetch: memory model with programmable latency
// returning mem[k] = k + 0x100, plus a monitor logging requests and pops.
module tb_ifetch;

`ifdef IFETCH_PREFETCH_EN
   localparam int unsigned EXP_REQS = 2;
`else
   localparam int unsigned EXP_REQS = 1;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        run = 1'b0;
   logic        jmp_en = 1'b0;
   logic [7:0]  jmp_addr = 8'h00;
   logic        mem_req;
   logic [7:0]  mem_addr;
   logic        mem_rvalid;
   logic [15:0] mem_rdata;
   logic [15:0] ins;
   logic        ins_valid;
   logic        ins_ready = 1'b1;
   logic [7:0]  pc;

   int n_checks = 0;
   int n_errors = 0;

   ifetch #(.DWIDTH(16), .AWIDTH(8)) dut (
      .clk(clk), .rst(rst), .run(run), .jmp_en(jmp_en), .jmp_addr(jmp_addr),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_rvalid(mem_rvalid),
      .mem_rdata(mem_rdata), .ins(ins), .ins_valid(ins_valid),
      .ins_ready(ins_ready), .pc(pc)
   );

   always #5 clk = ~clk;

   // Memory model: one response, lat cycles after the request cycle
   int         lat = 1;
   logic       pend;
   logic [7:0] paddr;
   int         left;
   initial begin
      pend = 1'b0; left = 0; paddr = 8'h00;
      mem_rvalid = 1'b0; mem_rdata = 16'h0000;
      forever begin
         @(posedge clk); #1;
         mem_rvalid = 1'b0;
         if (pend) begin
            left = left - 1;
            if (left == 0) begin
               mem_rvalid = 1'b1;
               mem_rdata  = 16'h0100 + 16'(paddr);
               pend       = 1'b0;
            end
         end
         if (mem_req === 1'b1) begin
            pend = 1'b1; paddr = mem_addr; left = lat;
         end
      end
   end

   // Monitor: request addresses/cycles and accepted instructions
   int          cyc = 0;
   logic [7:0]  req_addr_q[$];
   int          req_cyc_q[$];
   logic [15:0] pop_q[$];
   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (mem_req === 1'b1) begin
         req_addr_q.push_back(mem_addr);
         req_cyc_q.push_back(cyc);
      end
      if (ins_valid === 1'b1 && ins_ready && !jmp_en && !rst) pop_q.push_back(ins);
   end

   task automatic tick();
      @(posedge clk); #2;
   endtask

   task automatic clear_logs();
      req_addr_q.delete(); req_cyc_q.delete(); pop_q.delete();
   endtask

   task automatic quiesce();
      run = 1'b0; jmp_en = 1'b0; ins_ready = 1'b1;
      repeat (8) tick();
   endtask

   task automatic do_reset();
      quiesce();
      rst = 1'b1; tick(); tick(); rst = 1'b0;
      clear_logs();
   endtask

   task automatic wait_req(input int max, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max; i++) begin
         tick();
         if (mem_req === 1'b1) begin ok = 1'b1; break; end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      n_checks++; if (mem_req !== 1'b0) begin n_errors++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
      n_checks++; if (pc !== 8'h00) begin n_errors++; $display("FAIL reset_pc: got %h want 00", pc); end
      n_checks++; if (ins_valid !== 1'b0) begin n_errors++; $display("FAIL reset_ins_valid: got %b want 0", ins_valid); end
      n_checks++; if (ins !== 16'h0000) begin n_errors++; $display("FAIL reset_ins: got %h want 0000", ins); end
      rst = 1'b0;
      clear_logs();
   endtask

   task automatic test_stream();
      do_reset();
      lat = 1; ins_ready = 1'b1; run = 1'b1;
      repeat (14) tick();
      run = 1'b0;
      repeat (6) tick();
      n_checks++;
      if (req_addr_q.size() < 4 || pop_q.size() < 4) begin
         n_errors++; $display("FAIL stream_count: got %0d reqs %0d pops want >=4", req_addr_q.size(), pop_q.size());
      end else begin
         for (int k = 0; k < 4; k++) begin
            n_checks++; if (req_addr_q[k] !== 8'(k)) begin n_errors++; $display("FAIL stream_addr[%0d]: got %h want %h", k, req_addr_q[k], 8'(k)); end
            n_checks++; if (pop_q[k] !== 16'h0100 + 16'(k)) begin n_errors++; $display("FAIL stream_ins[%0d]: got %h want %h", k, pop_q[k], 16'h0100 + 16'(k)); end
         end
         for (int k = 1; k < 4; k++) begin
            n_checks++; if (req_cyc_q[k] - req_cyc_q[k-1] != 3) begin n_errors++; $display("FAIL stream_period[%0d]: got %0d want 3", k, req_cyc_q[k] - req_cyc_q[k-1]); end
         end
      end
   endtask

   task automatic test_wrap_latency();
      bit ok;
      quiesce();
      clear_logs();
      jmp_en = 1'b1; jmp_addr = 8'hFF; run = 1'b1;
      tick();
      jmp_en = 1'b0;
      n_checks++; if (mem_req !== 1'b0) begin n_errors++; $display("FAIL jmp_n1_req: got %b want 0", mem_req); end
      n_checks++; if (pc !== 8'hFF) begin n_errors++; $display("FAIL jmp_n1_pc: got %h want ff", pc); end
      tick();
      n_checks++; if (mem_req !== 1'b1 || mem_addr !== 8'hFF) begin n_errors++; $display("FAIL jmp_n2_req: got req=%b addr=%h want req=1 addr=ff", mem_req, mem_addr); end
      wait_req(10, ok);
      n_checks++; if (!ok || mem_addr !== 8'h00) begin n_errors++; $display("FAIL wrap_addr: got ok=%b addr=%h want ok=1 addr=00", ok, mem_addr); end
      run = 1'b0;
   endtask

   task automatic test_stall();
      do_reset();
      lat = 1; ins_ready = 1'b0; run = 1'b1;
      repeat (20) tick();
      n_checks++; if (req_addr_q.size() != int'(EXP_REQS)) begin n_errors++; $display("FAIL stall_reqs: got %0d want %0d", req_addr_q.size(), EXP_REQS); end
      n_checks++; if (mem_req !== 1'b0) begin n_errors++; $display("FAIL stall_mem_req: got %b want 0", mem_req); end
      n_checks++; if (ins_valid !== 1'b1) begin n_errors++; $display("FAIL stall_ins_valid: got %b want 1", ins_valid); end
      n_checks++; if (ins !== 16'h0100) begin n_errors++; $display("FAIL stall_ins: got %h want 0100", ins); end
      n_checks++; if (pc !== 8'(EXP_REQS)) begin n_errors++; $display("FAIL stall_pc: got %h want %h", pc, 8'(EXP_REQS)); end
   endtask

   task automatic test_jmp_full();
      clear_logs();
      jmp_en = 1'b1; jmp_addr = 8'h20; ins_ready = 1'b1;
      tick();
      jmp_en = 1'b0;
      n_checks++; if (ins_valid !== 1'b0) begin n_errors++; $display("FAIL full_jmp_valid: got %b want 0", ins_valid); end
      n_checks++; if (pc !== 8'h20) begin n_errors++; $display("FAIL full_jmp_pc: got %h want 20", pc); end
      n_checks++; if (ins !== 16'h0100) begin n_errors++; $display("FAIL full_jmp_ins: got %h want 0100", ins); end
      n_checks++; if (pop_q.size() != 0) begin n_errors++; $display("FAIL full_jmp_pop: got %0d pops want 0", pop_q.size()); end
      for (int i = 0; i < 15 && pop_q.size() == 0; i++) tick();
      n_checks++; if (pop_q.size() == 0 || pop_q[0] !== 16'h0120) begin n_errors++; $display("FAIL full_jmp_first_ins: got %0d pops head %h want 0120", pop_q.size(), pop_q.size() ? pop_q[0] : 16'h0); end
      run = 1'b0;
   endtask

   task automatic test_jmp_wait();
      bit ok;
      do_reset();
      lat = 3; ins_ready = 1'b1; run = 1'b1;
      wait_req(5, ok);
      n_checks++; if (!ok) begin n_errors++; $display("FAIL jw_first_req: got none want request"); end
      tick();
      jmp_en = 1'b1; jmp_addr = 8'h40;
      tick();
      jmp_en = 1'b0;
      repeat (12) tick();
      run = 1'b0;
      repeat (8) tick();
      n_checks++;
      if (req_addr_q.size() < 2) begin
         n_errors++; $display("FAIL jw_reqs: got %0d want >=2", req_addr_q.size());
      end else begin
         n_checks++; if (req_addr_q[1] !== 8'h40) begin n_errors++; $display("FAIL jw_addr: got %h want 40", req_addr_q[1]); end
         n_checks++; if (req_cyc_q[1] - req_cyc_q[0] != 5) begin n_errors++; $display("FAIL jw_gap: got %0d want 5", req_cyc_q[1] - req_cyc_q[0]); end
      end
      n_checks++; if (pop_q.size() == 0 || pop_q[0] !== 16'h0140) begin n_errors++; $display("FAIL jw_first_ins: got %0d pops head %h want 0140", pop_q.size(), pop_q.size() ? pop_q[0] : 16'h0); end
   endtask

   task automatic test_jmp_rvalid();
      bit ok;
      do_reset();
      lat = 3; ins_ready = 1'b1; run = 1'b1;
      wait_req(5, ok);
      n_checks++; if (!ok) begin n_errors++; $display("FAIL jr_first_req: got none want request"); end
      repeat (3) tick();
      jmp_en = 1'b1; jmp_addr = 8'h60;
      tick();
      jmp_en = 1'b0;
      n_checks++; if (pc !== 8'h60) begin n_errors++; $display("FAIL jr_pc: got %h want 60", pc); end
      n_checks++; if (ins_valid !== 1'b0) begin n_errors++; $display("FAIL jr_valid: got %b want 0", ins_valid); end
      repeat (12) tick();
      run = 1'b0;
      repeat (8) tick();
      n_checks++;
      if (req_addr_q.size() < 2 || req_addr_q[1] !== 8'h60 || req_cyc_q[1] - req_cyc_q[0] != 5) begin
         n_errors++; $display("FAIL jr_next_req: got %0d reqs addr %h gap %0d want addr 60 gap 5", req_addr_q.size(),
            req_addr_q.size() > 1 ? req_addr_q[1] : 8'h0, req_addr_q.size() > 1 ? req_cyc_q[1] - req_cyc_q[0] : 0);
      end
      n_checks++; if (pop_q.size() == 0 || pop_q[0] !== 16'h0160) begin n_errors++; $display("FAIL jr_first_ins: got %0d pops head %h want 0160", pop_q.size(), pop_q.size() ? pop_q[0] : 16'h0); end
   endtask

   task automatic test_reset_wait();
      bit ok;
      bit seen_valid;
      quiesce();
      clear_logs();
      lat = 3; run = 1'b1;
      wait_req(5, ok);
      n_checks++; if (!ok) begin n_errors++; $display("FAIL rw_first_req: got none want request"); end
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++; if (mem_req !== 1'b0) begin n_errors++; $display("FAIL rw_mem_req: got %b want 0", mem_req); end
      n_checks++; if (pc !== 8'h00) begin n_errors++; $display("FAIL rw_pc: got %h want 00", pc); end
      n_checks++; if (ins_valid !== 1'b0) begin n_errors++; $display("FAIL rw_ins_valid: got %b want 0", ins_valid); end
      n_checks++; if (ins !== 16'h0000) begin n_errors++; $display("FAIL rw_ins: got %h want 0000", ins); end
      seen_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (ins_valid !== 1'b0) seen_valid = 1'b1;
      end
      n_checks++; if (seen_valid) begin n_errors++; $display("FAIL rw_late_rvalid: got ins_valid=1 want 0"); end
      repeat (10) tick();
      run = 1'b0;
      repeat (8) tick();
      n_checks++;
      if (req_addr_q.size() < 2 || req_addr_q[1] !== 8'h00 || req_cyc_q[1] - req_cyc_q[0] != 5) begin
         n_errors++; $display("FAIL rw_next_req: got %0d reqs addr %h gap %0d want addr 00 gap 5", req_addr_q.size(),
            req_addr_q.size() > 1 ? req_addr_q[1] : 8'h0, req_addr_q.size() > 1 ? req_cyc_q[1] - req_cyc_q[0] : 0);
      end
      n_checks++; if (pop_q.size() == 0 || pop_q[0] !== 16'h0100) begin n_errors++; $display("FAIL rw_first_ins: got %0d pops head %h want 0100", pop_q.size(), pop_q.size() ? pop_q[0] : 16'h0); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_wrap_latency();
      test_stall();
      test_jmp_full();
      test_jmp_wait();
      test_jmp_rvalid();
      test_reset_wait();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
